// File: rtl/mod_acc_arbiter_pkg.sv
// Shared types and the round-robin pick function for the modular-accumulator arbiter.
package mod_acc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACCUM  = 2'd2,
    RESULT = 2'd3
  } arb_state_e;

  localparam int unsigned ARB_MAX_REQ = 32;
  localparam int unsigned ARB_ID_W    = $clog2(ARB_MAX_REQ);

  typedef struct packed {
    logic                found;
    logic [ARB_ID_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] at or above ptr, wrapping back to 0.
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      if (i < n && !res.found) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (req[k]) begin
          res.found = 1'b1;
          res.idx   = ARB_ID_W'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_acc_arbiter_if.sv
// Requester/result bundle between operand producers and the accumulator arbiter.
interface mod_acc_arbiter_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned LEN_W    = 8
);
  logic [NUM_REQ-1:0]          iReq;
  logic [NUM_REQ*LEN_W-1:0]    iLen;
  logic [BITWIDTH-1:0]         iQ;
  logic [NUM_REQ-1:0]          iValid;
  logic [NUM_REQ*BITWIDTH-1:0] iData;
  logic [NUM_REQ-1:0]          oReady;
  logic [NUM_REQ-1:0]          oGrant;
  logic                        oValid;
  logic                        iResReady;
  logic [BITWIDTH-1:0]         oData;
  logic [$clog2(NUM_REQ)-1:0]  oId;

  modport slave (
    input  iReq, iLen, iQ, iValid, iData, iResReady,
    output oReady, oGrant, oValid, oData, oId
  );

  modport master (
    output iReq, iLen, iQ, iValid, iData, iResReady,
    input  oReady, oGrant, oValid, oData, oId
  );
endinterface

// File: rtl/mod_acc_arbiter_accum.sv
// Modular accumulator: acc <= (acc + d) mod Q, assuming acc, d < Q.
module mod_accumulator #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iQ,
  output logic [BITWIDTH-1:0] oData
);
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [BITWIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, iData};
    acc_d = acc_q;
    if (iClr) begin
      acc_d = '0;
    end else if (iEn) begin
      // Both terms are below Q, so one conditional subtract completes the reduction.
      acc_d = (sum >= {1'b0, iQ}) ? BITWIDTH'(sum - {1'b0, iQ}) : sum[BITWIDTH-1:0];
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign oData = acc_q;
endmodule

// File: rtl/mod_acc_arbiter.sv
// Round-robin arbiter sharing one modular accumulator among NUM_REQ burst requesters.
module mod_acc_arbiter #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned LEN_W    = 8
) (
  input logic              iClk,
  input logic              iRstN,
  mod_acc_arbiter_if.slave bus
);
  import mod_acc_arb_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_e          state_q;
  logic [ID_W-1:0]     ptr_q, id_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [BITWIDTH-1:0] q_q;
  logic [NUM_REQ-1:0]  grant_q, ready_q;
  logic                valid_q;

  rr_pick_t            pick;
  logic [ID_W-1:0]     gnt_idx;
  logic [LEN_W-1:0]    len_sel;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [BITWIDTH-1:0] op_data, acc_data;
  logic                beat, clr;

  always_comb begin
    pick       = rr_pick(ARB_MAX_REQ'(bus.iReq), int'(ptr_q), NUM_REQ);
    gnt_idx    = ID_W'(pick.idx);
    len_sel    = bus.iLen[gnt_idx*LEN_W +: LEN_W];
    gnt_onehot = NUM_REQ'(1) << gnt_idx;
    op_data    = bus.iData[id_q*BITWIDTH +: BITWIDTH];
    beat       = ready_q[id_q] & bus.iValid[id_q];
    clr        = (state_q == CLEAR);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      grant_q <= '0;
      ready_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick.found) begin
            id_q    <= gnt_idx;
            len_q   <= len_sel;
            q_q     <= bus.iQ;
            cnt_q   <= '0;
            grant_q <= gnt_onehot;
            ptr_q   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (len_q != '0) begin
            ready_q <= grant_q;
            state_q <= ACCUM;
          end else begin
            valid_q <= 1'b1;
            state_q <= RESULT;
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            // Ready drops on the last beat edge so the sum is final when valid rises.
            if (cnt_q == len_q - 1'b1) begin
              ready_q <= '0;
              valid_q <= 1'b1;
              state_q <= RESULT;
            end
          end
        end
        RESULT: begin
          if (bus.iResReady) begin
            valid_q <= 1'b0;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mod_accumulator #(.BITWIDTH(BITWIDTH)) u_acc (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (beat),
    .iClr  (clr),
    .iData (op_data),
    .iQ    (q_q),
    .oData (acc_data)
  );

  assign bus.oGrant = grant_q;
  assign bus.oReady = ready_q;
  assign bus.oValid = valid_q;
  assign bus.oData  = acc_data;
  assign bus.oId    = id_q;
endmodule

// File: tb/tb_mod_acc_arbiter.sv
// Directed bench for mod_acc_arbiter: reset, round-robin, zero length, stalls, Q latch, mid-burst reset.
module tb_mod_acc_arbiter;
  localparam int unsigned BW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned LW = 8;

  logic clk, rst_n;
  int   total, bad;

  mod_acc_arbiter_if #(.BITWIDTH(BW), .NUM_REQ(NR), .LEN_W(LW)) bus ();

  mod_acc_arbiter #(.BITWIDTH(BW), .NUM_REQ(NR), .LEN_W(LW)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic set_len(input int k, input logic [LW-1:0] v);
    bus.iLen[k*LW +: LW] = v;
  endtask

  task automatic set_data(input int k, input logic [BW-1:0] v);
    bus.iData[k*BW +: BW] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iReq = '0; bus.iLen = '0; bus.iQ = '0; bus.iValid = '0; bus.iData = '0;
    bus.iResReady = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.oGrant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=%b", bus.oGrant, 4'b0000); end
    total++; if (bus.oReady !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=%b", bus.oReady, 4'b0000); end
    total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.oValid); end
    total++; if (bus.oId !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", bus.oId); end
    total++; if (bus.oData !== 32'd0) begin bad++; $display("FAIL rst_data got=%0d exp=0", bus.oData); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Requesters 0 and 2 both held: expect 0,2,0,2 with sum (5+6) mod 7 = 4.
  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_id;
    bus.iQ = 32'd7;
    set_len(0, 8'd2); set_len(2, 8'd2);
    set_data(0, 32'd5); set_data(2, 32'd5);
    bus.iValid = 4'b0101;
    bus.iReq   = 4'b0101;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      exp_g  = (b % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_id = (b % 2 == 0) ? 2'd0 : 2'd2;
      total++; if (bus.oGrant !== exp_g) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", b, bus.oGrant, exp_g); end
      total++; if (bus.oReady !== 4'b0000) begin bad++; $display("FAIL rr_clear_ready[%0d] got=%b exp=0000", b, bus.oReady); end
      set_data(0, 32'd5); set_data(2, 32'd5);
      @(negedge clk);
      total++; if (bus.oReady !== exp_g) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", b, bus.oReady, exp_g); end
      @(negedge clk);
      set_data(0, 32'd6); set_data(2, 32'd6);
      @(negedge clk);
      total++; if (bus.oValid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", b, bus.oValid); end
      total++; if (bus.oData !== 32'd4) begin bad++; $display("FAIL rr_data[%0d] got=%0d exp=4", b, bus.oData); end
      total++; if (bus.oId !== exp_id) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", b, bus.oId, exp_id); end
      @(negedge clk);
      total++; if (bus.oGrant !== 4'b0000 || bus.oValid !== 1'b0) begin bad++; $display("FAIL rr_idle_gap[%0d] grant=%b valid=%b exp=0000/0", b, bus.oGrant, bus.oValid); end
      if (b == 3) bus.iReq = '0;
      @(negedge clk);
    end
    total++; if (bus.oGrant !== 4'b0000) begin bad++; $display("FAIL rr_no_more got=%b exp=0000", bus.oGrant); end
    bus.iValid = '0;
  endtask

  // Q=13, four beats of 10: 40 mod 13 = 1, valid one cycle after the 4th beat.
  task automatic test_single_burst();
    bus.iQ = 32'd13;
    set_len(0, 8'd4);
    set_data(0, 32'd10);
    bus.iValid = 4'b0001;
    bus.iReq   = 4'b0001;
    @(negedge clk);
    bus.iReq = '0;
    total++; if (bus.oGrant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.oGrant); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.oReady !== 4'b0001 || bus.oValid !== 1'b0) begin bad++; $display("FAIL single_accum[%0d] ready=%b valid=%b exp=0001/0", k, bus.oReady, bus.oValid); end
    end
    @(negedge clk);
    total++; if (bus.oValid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.oValid); end
    total++; if (bus.oData !== 32'd1) begin bad++; $display("FAIL single_data got=%0d exp=1", bus.oData); end
    total++; if (bus.oId !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", bus.oId); end
    total++; if (bus.oReady !== 4'b0000) begin bad++; $display("FAIL single_result_ready got=%b exp=0000", bus.oReady); end
    @(negedge clk);
    bus.iValid = '0;
    total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b exp=0", bus.oValid); end
  endtask

  task automatic test_zero_len();
    set_len(3, 8'd0);
    bus.iValid = 4'b1000;
    bus.iReq   = 4'b1000;
    @(negedge clk);
    bus.iReq = '0;
    total++; if (bus.oGrant !== 4'b1000) begin bad++; $display("FAIL zero_grant got=%b exp=1000", bus.oGrant); end
    total++; if (bus.oReady !== 4'b0000) begin bad++; $display("FAIL zero_clear_ready got=%b exp=0000", bus.oReady); end
    @(negedge clk);
    total++; if (bus.oValid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b exp=1", bus.oValid); end
    total++; if (bus.oData !== 32'd0) begin bad++; $display("FAIL zero_data got=%0d exp=0", bus.oData); end
    total++; if (bus.oId !== 2'd3) begin bad++; $display("FAIL zero_id got=%0d exp=3", bus.oId); end
    total++; if (bus.oReady !== 4'b0000) begin bad++; $display("FAIL zero_result_ready got=%b exp=0000", bus.oReady); end
    @(negedge clk);
    bus.iValid = '0;
  endtask

  // 12+12+12 mod 13 = 10; requester 0's valid traffic must be ignored.
  task automatic test_stall_backpressure();
    bus.iQ = 32'd13;
    set_len(1, 8'd3);
    set_data(1, 32'd12);
    set_data(0, 32'd5);
    bus.iValid    = 4'b0001;
    bus.iResReady = 1'b0;
    bus.iReq      = 4'b0010;
    @(negedge clk);
    bus.iReq = 4'b0001;
    total++; if (bus.oGrant !== 4'b0010) begin bad++; $display("FAIL stall_grant got=%b exp=0010", bus.oGrant); end
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      bus.iValid = 4'b0011;
      total++; if (bus.oReady !== 4'b0010) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0010", b, bus.oReady); end
      @(negedge clk);
      bus.iValid = 4'b0001;
      if (b < 2) begin
        repeat (3) begin
          total++; if (bus.oValid !== 1'b0 || bus.oReady !== 4'b0010) begin bad++; $display("FAIL stall_gap[%0d] valid=%b ready=%b exp=0/0010", b, bus.oValid, bus.oReady); end
          @(negedge clk);
        end
      end
    end
    total++; if (bus.oValid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", bus.oValid); end
    total++; if (bus.oData !== 32'd10) begin bad++; $display("FAIL stall_data got=%0d exp=10", bus.oData); end
    total++; if (bus.oId !== 2'd1) begin bad++; $display("FAIL stall_id got=%0d exp=1", bus.oId); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bus.oValid !== 1'b1 || bus.oData !== 32'd10 || bus.oGrant !== 4'b0010) begin bad++; $display("FAIL bp_hold[%0d] valid=%b data=%0d grant=%b exp=1/10/0010", c, bus.oValid, bus.oData, bus.oGrant); end
    end
    bus.iResReady = 1'b1;
    bus.iReq      = '0;
    bus.iValid    = '0;
    @(negedge clk);
    total++; if (bus.oValid !== 1'b0 || bus.oGrant !== 4'b0000) begin bad++; $display("FAIL bp_release valid=%b grant=%b exp=0/0000", bus.oValid, bus.oGrant); end
    @(negedge clk);
    total++; if (bus.oGrant !== 4'b0000) begin bad++; $display("FAIL bp_no_regrant got=%b exp=0000", bus.oGrant); end
  endtask

  // 6+6 mod 13 = 12 (would be 5 if the mid-burst Q=7 leaked in).
  task automatic test_q_latch();
    bus.iQ = 32'd13;
    set_len(2, 8'd2);
    set_data(2, 32'd6);
    bus.iValid = 4'b0100;
    bus.iReq   = 4'b0100;
    @(negedge clk);
    bus.iReq = '0;
    bus.iQ   = 32'd7;
    total++; if (bus.oGrant !== 4'b0100) begin bad++; $display("FAIL qlat_grant got=%b exp=0100", bus.oGrant); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.oValid !== 1'b1 || bus.oData !== 32'd12) begin bad++; $display("FAIL qlat_data valid=%b data=%0d exp=1/12", bus.oValid, bus.oData); end
    total++; if (bus.oId !== 2'd2) begin bad++; $display("FAIL qlat_id got=%0d exp=2", bus.oId); end
    @(negedge clk);
    bus.iValid = '0;
  endtask

  task automatic test_reset_mid_burst();
    bus.iQ = 32'd13;
    set_len(2, 8'd5);
    set_data(2, 32'd9);
    bus.iValid = 4'b0100;
    bus.iReq   = 4'b0100;
    @(negedge clk);
    bus.iReq = '0;
    total++; if (bus.oGrant !== 4'b0100) begin bad++; $display("FAIL rmid_grant got=%b exp=0100", bus.oGrant); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.oGrant !== 4'b0000 || bus.oReady !== 4'b0000) begin bad++; $display("FAIL rmid_gr grant=%b ready=%b exp=0000/0000", bus.oGrant, bus.oReady); end
    total++; if (bus.oValid !== 1'b0 || bus.oId !== 2'd0) begin bad++; $display("FAIL rmid_vid valid=%b id=%0d exp=0/0", bus.oValid, bus.oId); end
    total++; if (bus.oData !== 32'd0) begin bad++; $display("FAIL rmid_data got=%0d exp=0", bus.oData); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.iValid = 4'b0001;
    set_len(0, 8'd1);
    set_data(0, 32'd9);
    bus.iReq = 4'b0001;
    @(negedge clk);
    bus.iReq = '0;
    total++; if (bus.oGrant !== 4'b0001) begin bad++; $display("FAIL post_grant got=%b exp=0001", bus.oGrant); end
    @(negedge clk);
    total++; if (bus.oReady !== 4'b0001) begin bad++; $display("FAIL post_ready got=%b exp=0001", bus.oReady); end
    @(negedge clk);
    total++; if (bus.oValid !== 1'b1 || bus.oData !== 32'd9) begin bad++; $display("FAIL post_data valid=%b data=%0d exp=1/9", bus.oValid, bus.oData); end
    total++; if (bus.oId !== 2'd0) begin bad++; $display("FAIL post_id got=%0d exp=0", bus.oId); end
    @(negedge clk);
    bus.iValid = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_zero_len();
    test_stall_backpressure();
    test_q_latch();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
